time_display_scan: RTL
======================

# time_display_scan

Downstream display stage for the stopwatch timer. Takes the 8-bit binary hours/minutes/seconds counts from the timer and converts each to two BCD digits. It time-multiplexes the six digits onto a common-anode 7-segment bank. Values are snapshotted once per scan frame so a display frame never mixes old and new time values.

## Interface
- DIV, 1000, clk cycles each digit is held active (minimum 2)
- clk  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- th  input  8  hours count, binary
- tm  input  8  minutes count, binary
- ts  input  8  seconds count, binary
- an  output  6  digit enables, active-low, one-hot; an[0] = rightmost (seconds units), an[5] = hours tens
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- frame_start  output  1  one-cycle pulse, the cycle the snapshot is loaded

## Operation
- Refresh counter `cnt` counts 0..DIV-1 and wraps. Width is clog2(DIV).
- Digit index `idx` counts 0..5 and advances when cnt==DIV-1. It wraps 5→0.
- Frame boundary is cnt==DIV-1 && idx==5. In that cycle:
  - th/tm/ts are registered into the snapshot registers `s_h`, `s_m`, `s_s`.
  - frame_start is 1 in that cycle only (combinational from cnt/idx).
- Digit map:
  - idx0 = s_s units, idx1 = s_s tens
  - idx2 = s_m units, idx3 = s_m tens
  - idx4 = s_h units, idx5 = s_h tens
- BCD conversion: tens = v/10, units = v%10, for 0 ≤ v ≤ 99.
- Out of range: a snapshot value ≥ 100 shows dash (seg=7'h3F) on both of its digits.
- Glyphs: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex), blank=7F.
- dp=0 (lit) on idx2 and idx4, giving the hh.mm.ss separators. dp=1 otherwise.
- an = ~(6'b1 << idx).
- Inputs are sampled only at frame boundaries. Changes to th/tm/ts mid-frame have no visible effect until the next frame.

## Timing
- Reset (synchronous, active-high, highest priority) sets:
  - cnt=0, idx=0, snapshots=0
  - an=6'h3F, seg=7'h7F, dp=1
  - frame_start is 0 during reset.
- an, seg and dp are registered. They reflect the idx/snapshot state of the previous cycle, giving one cycle of latency.
  - First cycle after reset release: outputs still hold their reset values.
  - Second cycle after reset release: an=6'h3E, seg=7'h40 (digit 0 of the zero snapshot).
- Frame length is exactly 6·DIV cycles. The first boundary after reset falls on cycle 6·DIV after release, counting the release cycle as 1.
- Snapshot updated at a boundary: the new digit 0 appears on the outputs in the next cycle.
- Reset asserted mid-frame: the next edge returns every register to its reset value. The partial frame is discarded and no frame_start pulse is produced.
- No input handshake. The block never stalls.

## Configuration
- `TDM_LZ_BLANK_EN` defined: the hours-tens digit (idx5) shows blank (seg=7'h7F, an still driven) when s_h < 10. All other digits are unaffected.
- `TDM_LZ_BLANK_EN` undefined: idx5 always shows the tens glyph, so a leading 0 is displayed.

## Test plan
Bench uses DIV=4 throughout.
1. **Reset values.** Assert reset with th/tm/ts=0 → an=3F, seg=7F, dp=1, frame_start=0. Release reset → one cycle later an=3E, seg=40.
2. **Snapshot and frame.** Set th=12, tm=34, ts=56 right after reset release.
   - frame_start pulses on cycle 24.
   - The next frame shows, in order, (an,seg,dp): (3E,02,1), (3D,12,1), (3B,19,0), (37,30,1), (2F,24,0), (1F,79,1), each held 4 cycles.
3. **Tear-free.** Change ts from 56 to 57 during cycle 10 of a frame → the current frame still shows 6. The following frame shows 7 (seg=78).
4. **Range boundaries.**
   - ts=59 → digits 9 (10) and 5 (12).
   - ts=0 → 40, 40.
   - ts=100 → 3F, 3F.
5. **Leading-zero blanking.** th=7, with and without `TDM_LZ_BLANK_EN`:
   - Defined: idx5 seg=7F. th=10 → idx5 seg=79.
   - Undefined: idx5 seg=40.
6. **Mid-frame reset.** Assert reset during idx=3 → the next cycle gives an=3F, seg=7F. After release the scan restarts at idx0, and the first frame_start pulse comes 24 cycles after release.

Source files
------------

// File: rtl/time_display_scan.sv
// -----------------------------------------------------------------------------
// time_display_scan
//
// Display stage for the stopwatch timer. Takes the binary hours, minutes and
// seconds counts and splits each into two BCD digits. The six digits are
// time-multiplexed onto a common-anode 7-segment bank. The inputs are captured
// once per scan frame, so a single frame never mixes an old and a new time.
//
// Parameters:
//   DIV          clk cycles each digit is held active (>= 2)
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset (highest priority)
//   th, tm, ts   hours / minutes / seconds counts, binary, 8 bits each
//   an           digit enables, active-low, one-hot (an[0] = seconds units)
//   seg          segments {g,f,e,d,c,b,a}, active-low, registered
//   dp           decimal point, active-low, registered (lit on idx2 and idx4)
//   frame_start  one-cycle pulse in the cycle the snapshot is loaded
//
// Build option:
//   TDM_LZ_BLANK_EN  when defined, the hours-tens digit is blanked whenever
//                    the hours snapshot is below 10 (leading-zero blanking).
// -----------------------------------------------------------------------------
module time_display_scan #(
  parameter int DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] th,
  input  logic [7:0] tm,
  input  logic [7:0] ts,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int               CNT_W     = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [2:0]       IDX_LAST  = 3'd5;
  localparam logic [6:0]       SEG_BLANK = 7'h7F;
  localparam logic [6:0]       SEG_DASH  = 7'h3F;

  // Active-low 7-segment pattern for one decimal digit.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  // Tens digit of a value already known to be in 0..99.
  function automatic logic [3:0] bcd_tens(input logic [7:0] v);
    return 4'(v / 8'd10);
  endfunction

  // Units digit of a value already known to be in 0..99.
  function automatic logic [3:0] bcd_units(input logic [7:0] v);
    return 4'(v % 8'd10);
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       s_h_q, s_h_d;
  logic [7:0]       s_m_q, s_m_d;
  logic [7:0]       s_s_q, s_s_d;
  logic [5:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             cnt_last_s;
  logic             boundary_s;
  logic [7:0]       val_s;
  logic             use_tens_s;
  logic             lz_blank_s;

  assign cnt_last_s  = (cnt_q == CNT_LAST);
  assign boundary_s  = cnt_last_s && (idx_q == IDX_LAST);
  // Gated by reset so no pulse escapes while a partial frame is being discarded.
  assign frame_start = boundary_s && !reset;

`ifdef TDM_LZ_BLANK_EN
  assign lz_blank_s = (idx_q == IDX_LAST) && (s_h_q < 8'd10);
`else
  assign lz_blank_s = 1'b0;
`endif

  // Refresh counter, digit index and frame-boundary snapshot next state.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    s_h_d = s_h_q;
    s_m_d = s_m_q;
    s_s_d = s_s_q;
    if (cnt_last_s) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = 3'd0;
        s_h_d = th;
        s_m_d = tm;
        s_s_d = ts;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Select the snapshot and digit half shown for the current index.
  always_comb begin
    val_s      = 8'd0;
    use_tens_s = 1'b0;
    case (idx_q)
      3'd0:    begin val_s = s_s_q; use_tens_s = 1'b0; end
      3'd1:    begin val_s = s_s_q; use_tens_s = 1'b1; end
      3'd2:    begin val_s = s_m_q; use_tens_s = 1'b0; end
      3'd3:    begin val_s = s_m_q; use_tens_s = 1'b1; end
      3'd4:    begin val_s = s_h_q; use_tens_s = 1'b0; end
      3'd5:    begin val_s = s_h_q; use_tens_s = 1'b1; end
      default: begin val_s = 8'd0;  use_tens_s = 1'b0; end
    endcase
  end

  // Next values for the registered anode, segment and decimal-point outputs.
  always_comb begin
    an_d = ~(6'b000001 << idx_q);
    dp_d = ~((idx_q == 3'd2) || (idx_q == 3'd4));
    // Out-of-range dash wins over blanking; blanking only applies below 10.
    if (val_s > 8'd99) begin
      seg_d = SEG_DASH;
    end else if (lz_blank_s) begin
      seg_d = SEG_BLANK;
    end else if (use_tens_s) begin
      seg_d = glyph(bcd_tens(val_s));
    end else begin
      seg_d = glyph(bcd_units(val_s));
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= 3'd0;
      s_h_q <= 8'd0;
      s_m_q <= 8'd0;
      s_s_q <= 8'd0;
      an_q  <= 6'h3F;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      s_h_q <= s_h_d;
      s_m_q <= s_m_d;
      s_s_q <= s_s_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
